// File: rtl/knn_sort_ctrl_if.sv
// Bus bundle for knn_sort_ctrl: distance input stream, sorter control/result, sorted output stream.
// master = the controller; slave = the surrounding datapath and result consumer.
interface knn_sort_ctrl_if #(
  parameter int W  = 32,
  parameter int K  = 4,
  parameter int KW = $clog2(K)
);
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;

  logic           srt_clr;
  logic           srt_en;
  logic [W-1:0]   srt_data;
  logic [K*W-1:0] srt_res;

  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [KW-1:0]  out_idx;
  logic           out_last;
  logic           out_ready;

  modport master (
    input  in_valid, in_data, srt_res, out_ready,
    output in_ready, srt_clr, srt_en, srt_data, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output in_valid, in_data, srt_res, out_ready,
    input  in_ready, srt_clr, srt_en, srt_data, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/knn_sort_ctrl.sv
// Sequencer for the K-slot insertion sorter: clear, stream n_pts distances in, drain K slots out.
// Optional macro KNN_SORT_CTRL_PERF_EN adds busy-cycle and input-stall counters.
module knn_sort_ctrl #(
  parameter int W  = 32,
  parameter int K  = 4,
  parameter int NW = 16,
  parameter int KW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_pts,
  output logic          busy,
  output logic          done,
`ifdef KNN_SORT_CTRL_PERF_EN
  output logic [31:0]   cycles,
  output logic [NW-1:0] stalls,
`endif
  knn_sort_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [NW-1:0] cnt_reg;
  logic [KW-1:0] idx_reg;
  logic          srt_en_reg;
  logic [W-1:0]  srt_data_reg;
  logic          in_hs, out_hs, last;
  logic [W-1:0]  slot [K];

  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    assign slot[gi] = bus.srt_res[gi*W +: W];
  end

  assign in_hs  = bus.in_valid && (state_reg == LOAD);
  assign out_hs = bus.out_ready && (state_reg == DRAIN);
  assign last   = (idx_reg == KW'(K - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = (cnt_reg != '0) ? LOAD : FLUSH;
      LOAD:    if (in_hs && cnt_reg == NW'(1)) state_next = FLUSH;
      FLUSH:   state_next = DRAIN;
      DRAIN:   if (out_hs && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    bus.srt_clr   = (state_reg == CLEAR);
    bus.in_ready  = (state_reg == LOAD);
    bus.out_valid = (state_reg == DRAIN);
    bus.out_idx   = '0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (state_reg == DRAIN) begin
      bus.out_idx  = idx_reg;
      bus.out_data = slot[idx_reg];
      bus.out_last = last;
    end
  end

  // The insert strobe is registered, so FLUSH exists to let the final insert land before DRAIN reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg      <= '0;
      idx_reg      <= '0;
      srt_en_reg   <= 1'b0;
      srt_data_reg <= '0;
    end else begin
      srt_en_reg <= in_hs;
      if (in_hs) begin
        srt_data_reg <= bus.in_data;
        cnt_reg      <= cnt_reg - NW'(1);
      end
      if (state_reg == IDLE && start) cnt_reg <= n_pts;
      if (state_reg == FLUSH)  idx_reg <= '0;
      else if (out_hs)         idx_reg <= idx_reg + KW'(1);
    end
  end

  assign bus.srt_en   = srt_en_reg;
  assign bus.srt_data = srt_data_reg;

`ifdef KNN_SORT_CTRL_PERF_EN
  logic [31:0]   cycles_reg;
  logic [NW-1:0] stalls_reg;

  // Both counters saturate and hold through IDLE until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_reg <= '0;
      stalls_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      cycles_reg <= '0;
      stalls_reg <= '0;
    end else begin
      if (busy && cycles_reg != '1) cycles_reg <= cycles_reg + 32'd1;
      if (state_reg == LOAD && !bus.in_valid && stalls_reg != '1)
        stalls_reg <= stalls_reg + NW'(1);
    end
  end

  assign cycles = cycles_reg;
  assign stalls = stalls_reg;
`endif

endmodule
